// File: rtl/mul_shift_64clk_add_pkg.sv
// Shared muldiv definitions: FSM encoding, iteration bounds and signedness codes
// used by the shift multiplier and the shift divider.
package mul_shift_64clk_add_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    localparam logic [CNT_W-1:0] CNT_MAX     = 7'd63;
    localparam logic [CNT_W-1:0] CNT_START   = 7'd0;
    localparam logic [CNT_W-1:0] CNT_W_START = 7'd32;
    localparam logic [CNT_W-1:0] CNT_ONE     = 7'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // mul_signed: [1] multiplicand signed, [0] multiplier signed; 01 behaves as 00
    localparam logic [1:0] MUL_SS = 2'b11;
    localparam logic [1:0] MUL_SU = 2'b10;
    localparam logic [1:0] MUL_UU = 2'b00;

    localparam logic DIV_SIGNED   = 1'b1;
    localparam logic DIV_UNSIGNED = 1'b0;

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
        logic [XLEN-1:0] r;
        if (s) begin
            r = {{32{v[31]}}, v};
        end else begin
            r = {32'd0, v};
        end
        return r;
    endfunction

    function automatic logic mcand_is_signed(input logic [1:0] ms);
        return ms[1];
    endfunction

    function automatic logic mplr_is_signed(input logic [1:0] ms);
        return (ms == MUL_SS);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement of a W-bit value; shared by the multiplier and
// divider for operand magnitudes and for restoring the result sign.
module muldiv_sign_fix #(
    parameter int W = 64
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    // Negate when requested, pass through otherwise
    always_comb begin
        o_val = i_val;
        if (i_neg) begin
            o_val = ~i_val + W'(1);
        end else begin
            o_val = i_val;
        end
    end

endmodule

// File: rtl/mul_shift_64clk_add.sv
// Iterative shift-add multiplier: one multiplier bit per clock over a 129-bit
// {acc, mplr} register; 128-bit product for 64-bit ops, 64-bit for MULW.
module mul_shift_64clk_add
    import mul_shift_64clk_add_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mul_valid,
    input  logic              flush,
    input  logic              mulw,
    input  logic [1:0]        mul_signed,
    input  logic [XLEN-1:0]   multiplicand,
    input  logic [XLEN-1:0]   multiplier,
    output logic              mul_ready,
    output logic              out_valid,
    output logic [XLEN-1:0]   result_lo,
    output logic [XLEN-1:0]   result_hi
);

    md_state_e           r_state;
    md_state_e           w_state_next;
    logic                r_mul_ready;
    logic                w_mul_ready_next;
    logic                r_out_valid;
    logic                w_out_valid_next;
    logic                w_load;
    logic                w_step;
    logic                w_last;
    logic                w_hs;
    logic                w_kill;

    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN:0]       r_acc;
    logic [XLEN-1:0]     r_mplr;
    logic [XLEN-1:0]     r_mcand;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [1:0]          r_signed;
    logic                r_mulw;
    logic [XLEN-1:0]     r_result_lo;
    logic [XLEN-1:0]     r_result_hi;

    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_a_ext;
    logic [XLEN-1:0]     w_b_ext;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_abs;
    logic [XLEN-1:0]     w_b_abs;

    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_acc_next;
    logic [XLEN-1:0]     w_mplr_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_fixed;
    logic                w_res_neg;
    logic [XLEN-1:0]     w_res_lo;
    logic [XLEN-1:0]     w_res_hi;

    assign w_hs   = mul_valid & r_mul_ready;
    assign w_kill = rst | flush;

    // Operand extension for MULW and per-operand sign decisions
    always_comb begin
        w_sa = mcand_is_signed(mul_signed);
        w_sb = mplr_is_signed(mul_signed);
        if (mulw) begin
            w_a_ext = ext32(multiplicand[31:0], w_sa);
            w_b_ext = ext32(multiplier[31:0], w_sb);
        end else begin
            w_a_ext = multiplicand;
            w_b_ext = multiplier;
        end
        w_a_neg = w_sa & w_a_ext[XLEN-1];
        w_b_neg = w_sb & w_b_ext[XLEN-1];
    end

    muldiv_sign_fix #(.W(XLEN)) u_abs_a (
        .i_neg (w_a_neg),
        .i_val (w_a_ext),
        .o_val (w_a_abs)
    );

    muldiv_sign_fix #(.W(XLEN)) u_abs_b (
        .i_neg (w_b_neg),
        .i_val (w_b_ext),
        .o_val (w_b_abs)
    );

    // One shift-add step: conditional add into acc, then shift {acc,mplr} right
    always_comb begin
        if (r_mplr[0]) begin
            w_sum = r_acc + {1'b0, r_mcand};
        end else begin
            w_sum = r_acc;
        end
        w_acc_next  = {1'b0, w_sum[XLEN:1]};
        w_mplr_next = {w_sum[0], r_mplr[XLEN-1:1]};
    end

    // After 32 steps the 32x32 product sits in bits [95:32] of {acc,mplr}
    always_comb begin
        if (r_mulw) begin
            w_prod = {64'd0, w_acc_next[31:0], w_mplr_next[XLEN-1:32]};
        end else begin
            w_prod = {w_acc_next[XLEN-1:0], w_mplr_next};
        end
        w_res_neg = (mcand_is_signed(r_signed) & r_sign_a) ^
                    (mplr_is_signed(r_signed) & r_sign_b);
    end

    muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
        .i_neg (w_res_neg),
        .i_val (w_prod),
        .o_val (w_prod_fixed)
    );

    // Map the signed-fixed product onto the lo/hi result words
    always_comb begin
        if (r_mulw) begin
            w_res_lo = {{32{w_prod_fixed[31]}}, w_prod_fixed[31:0]};
            w_res_hi = w_prod_fixed[XLEN-1:0];
        end else begin
            w_res_lo = w_prod_fixed[XLEN-1:0];
            w_res_hi = w_prod_fixed[2*XLEN-1:XLEN];
        end
    end

    // Next-state, handshake and completion decode
    always_comb begin
        w_state_next     = r_state;
        w_mul_ready_next = 1'b0;
        w_out_valid_next = 1'b0;
        w_load           = 1'b0;
        w_step           = 1'b0;
        w_last           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_state_next = ST_BUSY;
                    w_load       = 1'b1;
                end else begin
                    w_mul_ready_next = 1'b1;
                end
            end
            ST_BUSY: begin
                w_step = 1'b1;
                if (r_cnt == CNT_MAX) begin
                    w_state_next     = ST_IDLE;
                    w_out_valid_next = 1'b1;
                    w_last           = 1'b1;
                end else begin
                    w_state_next = ST_BUSY;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered handshake outputs; flush acts like reset
    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_state     <= ST_IDLE;
            r_mul_ready <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mul_ready <= w_mul_ready_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    // Operand capture, iteration datapath and result holding registers
    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_cnt       <= CNT_START;
            r_acc       <= '0;
            r_mplr      <= '0;
            r_mcand     <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_signed    <= MUL_UU;
            r_mulw      <= 1'b0;
            r_result_lo <= '0;
            r_result_hi <= '0;
        end else if (w_load) begin
            r_cnt    <= mulw ? CNT_W_START : CNT_START;
            r_acc    <= '0;
            r_mplr   <= w_b_abs;
            r_mcand  <= w_a_abs;
            r_sign_a <= w_a_ext[XLEN-1];
            r_sign_b <= w_b_ext[XLEN-1];
            r_signed <= mul_signed;
            r_mulw   <= mulw;
        end else if (w_step) begin
            r_cnt  <= r_cnt + CNT_ONE;
            r_acc  <= w_acc_next;
            r_mplr <= w_mplr_next;
            if (w_last) begin
                r_result_lo <= w_res_lo;
                r_result_hi <= w_res_hi;
            end
        end
    end

    assign mul_ready = r_mul_ready;
    assign out_valid = r_out_valid;
    assign result_lo = r_result_lo;
    assign result_hi = r_result_hi;

endmodule

// File: tb/tb_mul_shift_64clk_add.sv
// Self-checking bench: cycle-level behavioural model with plain-arithmetic
// products, per-cycle comparison, directed cases and randomized operations.
module tb_mul_shift_64clk_add;

    logic         clk;
    logic         rst;
    logic         mul_valid;
    logic         flush;
    logic         mulw;
    logic [1:0]   mul_signed;
    logic [63:0]  multiplicand;
    logic [63:0]  multiplier;
    logic         mul_ready;
    logic         out_valid;
    logic [63:0]  result_lo;
    logic [63:0]  result_hi;

    int tests = 0;
    int fails = 0;

    mul_shift_64clk_add dut (
        .clk          (clk),
        .rst          (rst),
        .mul_valid    (mul_valid),
        .flush        (flush),
        .mulw         (mulw),
        .mul_signed   (mul_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result_lo    (result_lo),
        .result_hi    (result_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {hi, lo} computed as an ordinary signed/unsigned product
    function automatic logic [127:0] model_product(input logic [63:0] a, input logic [63:0] b,
                                                   input logic [1:0] ms, input logic w);
        logic sa, sb;
        logic [127:0] ea, eb, p;
        logic [63:0] a64, b64, p64;
        sa = ms[1];
        sb = (ms == 2'b11);
        if (!w) begin
            ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
            eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
            p  = ea * eb;
            return p;
        end else begin
            a64 = sa ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            b64 = sb ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
            p64 = a64 * b64;
            return {p64, {{32{p64[31]}}, p64[31:0]}};
        end
    endfunction

    // Cycle-level expectation: latency countdown, ready/valid and held result
    logic        m_ready = 1'b0;
    logic        m_valid = 1'b0;
    logic [63:0] m_lo = 64'd0;
    logic [63:0] m_hi = 64'd0;
    logic [63:0] pend_lo = 64'd0;
    logic [63:0] pend_hi = 64'd0;
    int          m_left = 0;
    logic        m_started = 1'b0;

    always @(posedge clk) begin
        if (rst || flush) begin
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_left  = 0;
            m_lo    = 64'd0;
            m_hi    = 64'd0;
        end else if (m_left != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_lo    = pend_lo;
                m_hi    = pend_hi;
            end else begin
                m_valid = 1'b0;
            end
        end else begin
            m_valid = 1'b0;
            if (mul_valid && m_ready) begin
                {pend_hi, pend_lo} = model_product(multiplicand, multiplier, mul_signed, mulw);
                m_left  = mulw ? 32 : 64;
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end
        m_started = 1'b1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            tests++;
            if (mul_ready !== m_ready || out_valid !== m_valid ||
                (m_left == 0 && (result_lo !== m_lo || result_hi !== m_hi))) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t ready got %b want %b, valid got %b want %b, lo got %h want %h, hi got %h want %h",
                         $time, mul_ready, m_ready, out_valid, m_valid, result_lo, m_lo, result_hi, m_hi);
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (mul_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (mul_ready !== 1'b1) begin
            check("wait_ready", {127'd0, mul_ready}, 128'd1);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] ms, input logic w);
        wait_ready();
        mulw         = w;
        mul_signed   = ms;
        multiplicand = a;
        multiplier   = b;
        mul_valid    = 1'b1;
        @(posedge clk);
        #1;
        mul_valid = 1'b0;
    endtask

    // Cycles from the handshake cycle T to the out_valid cycle; -1 on timeout
    task automatic wait_done(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic run_lit(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] ms, input logic w,
                           input logic [63:0] exp_lo, input logic [63:0] exp_hi, input int exp_lat);
        int lat;
        issue(a, b, ms, w);
        wait_done(lat);
        check({name, "_lat"}, 128'(lat), 128'(exp_lat));
        check({name, "_lo"}, {64'd0, result_lo}, {64'd0, exp_lo});
        check({name, "_hi"}, {64'd0, result_hi}, {64'd0, exp_hi});
        if (lat != -1) begin
            @(negedge clk);
            check({name, "_ready_after"}, {127'd0, mul_ready}, 128'd1);
        end
    endtask

    task automatic abort_mid(input string name, input logic use_rst);
        issue(64'd123456789, 64'd987654321, 2'b00, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check({name, "_ready_F1"}, {127'd0, mul_ready}, 128'd0);
        @(negedge clk);
        check({name, "_ready_F2"}, {127'd0, mul_ready}, 128'd1);
        run_lit({name, "_7x6"}, 64'd7, 64'd6, 2'b00, 1'b0, 64'd42, 64'd0, 65);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int cnt;
        logic [1:0] ms;
        logic w;
        logic [63:0] a, b;

        rst = 1'b1; flush = 1'b0; mul_valid = 1'b0; mulw = 1'b0;
        mul_signed = 2'b00; multiplicand = 64'd0; multiplier = 64'd0;

        check("pin_model_ss", model_product(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0),
              128'h0000_0000_0000_0000_8000_0000_0000_0000);
        check("pin_model_su", model_product(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0),
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0002);
        check("pin_model_w", model_product(64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 2'b11, 1'b1),
              128'h0000_0000_FFFF_FFFE_FFFF_FFFF_FFFF_FFFE);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {127'd0, mul_ready}, 128'd0);
        check("reset_valid", {127'd0, out_valid}, 128'd0);
        check("reset_result", {result_hi, result_lo}, 128'd0);
        @(negedge clk);
        check("ready_after_reset", {127'd0, mul_ready}, 128'd1);

        run_lit("uu_3x5", 64'd3, 64'd5, 2'b00, 1'b0, 64'd15, 64'd0, 65);
        run_lit("ss_m1xm1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0,
                64'd1, 64'd0, 65);
        run_lit("ss_min", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0,
                64'h8000_0000_0000_0000, 64'd0, 65);
        run_lit("su", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0,
                64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_lit("mulw", 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 2'b11, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_FFFF_FFFE, 33);
        run_lit("zero", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 64'd0, 64'd0, 65);
        run_lit("ms01", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b01, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);

        abort_mid("flush", 1'b0);
        abort_mid("rst", 1'b1);

        // mul_valid held with changing operands while busy
        wait_ready();
        mulw = 1'b0; mul_signed = 2'b00;
        multiplicand = 64'h0000_0001_0000_0001; multiplier = 64'h10;
        mul_valid = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid) begin
                multiplicand = {$urandom, $urandom};
                multiplier   = {$urandom, $urandom};
            end
        end while (!out_valid && n < 100);
        mul_valid = 1'b0;
        check("busy_hold_lat", 128'(n), 128'd65);
        check("busy_hold_lo", {64'd0, result_lo}, 128'h10_0000_0010);
        check("busy_hold_hi", {64'd0, result_hi}, 128'd0);

        // flush coinciding with a handshake starts nothing
        wait_ready();
        multiplicand = 64'd9; multiplier = 64'd9;
        mul_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        mul_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_hs_ready", {127'd0, mul_ready}, 128'd0);
        cnt = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("flush_hs_no_valid", 128'(cnt), 128'd0);
        check("flush_hs_result", {result_hi, result_lo}, 128'd0);

        for (int i = 0; i < 40; i++) begin
            ms = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = pick();
            b  = pick();
            issue(a, b, ms, w);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 20)) begin
                    @(posedge clk);
                    #1;
                end
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end else begin
                wait_done(lat);
                check("rand_lat", 128'(lat), w ? 128'd33 : 128'd65);
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
